// File: rtl/gb_cpu_common_pkg.sv
// Shared definitions for the timer peripheral: register offsets, FSM states
// and the TAC tap-select decode.
package gb_cpu_common_pkg;

    localparam logic [1:0] DIV_OFS  = 2'd0;
    localparam logic [1:0] TIMA_OFS = 2'd1;
    localparam logic [1:0] TMA_OFS  = 2'd2;
    localparam logic [1:0] TAC_OFS  = 2'd3;

    typedef enum logic [1:0] {
        TIMER_RUN    = 2'd0,
        TIMER_OVF    = 2'd1,
        TIMER_RELOAD = 2'd2
    } timer_state_t;

    function automatic logic [3:0] tac_tap_bit(input logic [1:0] sel);
        logic [3:0] bit_idx;
        case (sel)
            2'b00:   bit_idx = 4'd9;
            2'b01:   bit_idx = 4'd3;
            2'b10:   bit_idx = 4'd5;
            default: bit_idx = 4'd7;
        endcase
        return bit_idx;
    endfunction

endpackage

// File: rtl/gb_timer_edge_detect.sv
// Registers the timer clock-select signal and flags its 1->0 transitions.
module gb_timer_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_fall
);

    logic r_sig_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sig_prev <= 1'b0;
        end else begin
            r_sig_prev <= i_sig;
        end
    end

    assign o_fall = r_sig_prev & ~i_sig;

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer: bus decode, register file, system counter and the
// overflow/reload sequence that raises the timer interrupt.
module gb_timer
    import gb_cpu_common_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_bus_addr,
    input  logic [7:0]  i_bus_data,
    input  logic        i_bus_wren,
    output logic [7:0]  o_bus_data,
    output logic        o_bus_hit,
    output logic        o_irq_timer,
    output logic [7:0]  o_div
);

    logic [15:0]  r_sys_cnt;
    logic [7:0]   r_tima;
    logic [7:0]   r_tma;
    logic [2:0]   r_tac;
    timer_state_t r_state;

    logic [15:0]  w_ofs;
    logic         w_wr_div;
    logic         w_wr_tima;
    logic         w_wr_tma;
    logic         w_wr_tac;
    logic         w_sig;
    logic         w_fall;
    logic [7:0]   w_tma_next;

    // Offset compare tolerates any BASE_ADDR alignment.
    assign w_ofs     = i_bus_addr - BASE_ADDR;
    assign o_bus_hit = (w_ofs < 16'd4);

    assign w_wr_div  = i_bus_wren & o_bus_hit & (w_ofs[1:0] == DIV_OFS);
    assign w_wr_tima = i_bus_wren & o_bus_hit & (w_ofs[1:0] == TIMA_OFS);
    assign w_wr_tma  = i_bus_wren & o_bus_hit & (w_ofs[1:0] == TMA_OFS);
    assign w_wr_tac  = i_bus_wren & o_bus_hit & (w_ofs[1:0] == TAC_OFS);

    assign w_tma_next = w_wr_tma ? i_bus_data : r_tma;

    assign w_sig = r_tac[2] & r_sys_cnt[tac_tap_bit(r_tac[1:0])];

    gb_timer_edge_detect u_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (w_sig),
        .o_fall  (w_fall)
    );

    always_comb begin
        o_bus_data = 8'hFF;
        if (o_bus_hit) begin
            case (w_ofs[1:0])
                DIV_OFS:  o_bus_data = r_sys_cnt[15:8];
                TIMA_OFS: o_bus_data = r_tima;
                TMA_OFS:  o_bus_data = r_tma;
                default:  o_bus_data = {5'b11111, r_tac};
            endcase
        end
    end

    assign o_div       = r_sys_cnt[15:8];
    assign o_irq_timer = (r_state == TIMER_RELOAD);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sys_cnt <= 16'h0000;
            r_tima    <= 8'h00;
            r_tma     <= 8'h00;
            r_tac     <= 3'b000;
            r_state   <= TIMER_RUN;
        end else begin
            r_sys_cnt <= w_wr_div ? 16'h0000 : r_sys_cnt + 16'd4;
            r_tma     <= w_tma_next;
            if (w_wr_tac) begin
                r_tac <= i_bus_data[2:0];
            end
            // TIMA is loaded with TMA on leaving OVF so it already reads the
            // reload value while the interrupt pulse is high.
            case (r_state)
                TIMER_RUN: begin
                    if (w_wr_tima) begin
                        r_tima <= i_bus_data;
                    end else if (w_fall) begin
                        if (r_tima == 8'hFF) begin
                            r_tima  <= 8'h00;
                            r_state <= TIMER_OVF;
                        end else begin
                            r_tima <= r_tima + 8'd1;
                        end
                    end
                end
                TIMER_OVF: begin
                    if (w_wr_tima) begin
                        r_tima  <= i_bus_data;
                        r_state <= TIMER_RUN;
                    end else begin
                        r_tima  <= w_tma_next;
                        r_state <= TIMER_RELOAD;
                    end
                end
                TIMER_RELOAD: begin
                    r_tima  <= w_tma_next;
                    r_state <= TIMER_RUN;
                end
                default: begin
                    r_state <= TIMER_RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/gb_timer.md
Name: gb_timer

Overview:
- Memory-mapped DIV/TIMA/TMA/TAC timer peripheral; the responder for the bus transactions the CPU scheduler initiates.
- Decodes CPU reads and writes on the address/data bus, keeps the 16-bit system counter, and raises the timer interrupt request.
- Clocked by the M-cycle clock; the internal counter advances by 4 T-cycles per M-cycle.

Parameters:
- BASE_ADDR, 16'hFF04, address of DIV. TIMA, TMA and TAC follow at +1, +2 and +3.

Ports:
- clk  input  1  M-cycle clock
- reset  input  1  synchronous, active-high reset
- bus_addr  input  16  CPU address bus
- bus_data_i  input  8  CPU write data
- bus_wren  input  1  write strobe for the current M-cycle
- bus_data_o  output  8  read data; combinational from the current register state
- bus_hit  output  1  bus_addr lies in BASE_ADDR..BASE_ADDR+3
- irq_timer  output  1  one-cycle interrupt request pulse, forwarded to the IF register
- div_o  output  8  current DIV value, for debug and APU frame sequencer

Behaviour:
- Reset values:
  - sys_cnt=16'h0000, TIMA=0, TMA=0, TAC=0.
  - State=RUN; irq_timer=0.
  - Reset wins over every simultaneous event.
- sys_cnt: +4 per cycle, wraps at 16 bits. DIV reads sys_cnt[15:8].
- Tap bit by TAC[1:0]: 00→bit9, 01→bit3, 10→bit5, 11→bit7.
- sig = TAC[2] & sys_cnt[tap]. TIMA increments on a 1→0 transition of sig between consecutive cycles; the edge detector is registered.
- Side effects of writes:
  - A DIV write clears sys_cnt.
  - A TAC write changes sig.
  - Either can produce a falling edge and a spurious TIMA increment. This is required behaviour.
- Reads:
  - DIV/TIMA/TMA return their values.
  - TAC returns {5'b11111, TAC[2:0]}.
  - A non-hit address returns 8'hFF with bus_hit=0.
- State machine over TIMA overflow:
  - RUN: an increment from 8'hFF sets TIMA=8'h00 and moves to OVF.
  - OVF (one cycle): TIMA reads 8'h00.
    - A TIMA write in this cycle loads bus_data_i, cancels the reload and irq, and returns to RUN.
    - Otherwise go to RELOAD.
  - RELOAD (one cycle):
    - TIMA←TMA and irq_timer=1 for this cycle.
    - A TIMA write here is ignored.
    - A TMA write here updates TMA, and TIMA takes the new value.
    - A falling edge here is ignored.
    - Return to RUN.
- Write versus increment in the same cycle in RUN: the write wins.
- Reset mid OVF/RELOAD: return to RUN with no irq.

Decomposition:
- gb_cpu_common_pkg gets:
  - localparams for the register offsets (DIV_OFS=0, TIMA_OFS=1, TMA_OFS=2, TAC_OFS=3);
  - a timer_state_t enum {TIMER_RUN, TIMER_OVF, TIMER_RELOAD};
  - a function tac_tap_bit(logic [1:0]) returning the bit index.
- One natural sub-module: gb_timer_edge_detect, which registers sig and outputs the falling-edge pulse.
- Register file, bus decode and the FSM stay in gb_timer.

Test Plan:
1. Reset, then TAC=3'b101 (bit3, enabled) → TIMA increments every 4 M-cycles. Read of FF07 = 8'hFD; read of FF00 gives bus_data_o=8'hFF, bus_hit=0.
2. TMA=8'hAB, TIMA=8'hFE, TAC=3'b101 → after 8 M-cycles:
   - TIMA reads 00 for one cycle;
   - the next cycle TIMA=AB and irq_timer=1 for exactly 1 cycle.
3. Same setup as 2, but write TIMA=8'h42 during the OVF cycle → TIMA=42, no irq, no reload.
4. Same setup as 2, but write TMA=8'h77 during the RELOAD cycle → TIMA=77 and irq pulses. A TIMA=8'h11 write in the RELOAD cycle is ignored (TIMA stays TMA).
5. TAC=3'b100 (bit9), advance until sys_cnt[9]=1, then write DIV → DIV reads 00 and TIMA increments by 1. Repeat with sys_cnt[9]=0 → no increment.
6. Assert reset during the OVF cycle → all outputs at reset values, no irq the following cycle. div_o wraps from FF to 00 after 16384 M-cycles.
